// File: rtl/parallel_to_serial_loader_pkg.sv
// Shared definitions for the parallel-to-serial loader: state encoding and
// the bit-counter width helper.
package parallel_to_serial_loader_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT
    } state_t;

    // Counter must reach SIZE-1; guard against a zero-width result.
    function automatic int cnt_width(input int size);
        return (size <= 2) ? 1 : $clog2(size);
    endfunction

endpackage

// File: rtl/parallel_to_serial_loader_if.sv
// Handshake and serial-output bundle between the word source, the loader
// and the downstream shift register.
interface parallel_to_serial_loader_if #(
    parameter int SIZE = 8
);
    logic [SIZE-1:0] data_in;
    logic            data_valid;
    logic            data_ready;
    logic            shift_ready;
    logic            out;
    logic            out_enable;
    logic            busy;
    logic            done;

    modport master (
        output data_in, data_valid, shift_ready,
        input  data_ready, out, out_enable, busy, done
    );

    modport slave (
        input  data_in, data_valid, shift_ready,
        output data_ready, out, out_enable, busy, done
    );
endinterface

// File: rtl/parallel_to_serial_loader_bit_counter.sv
// Counts consumed bits of the word in flight and flags the final bit.
module serializer_bit_counter
    import parallel_to_serial_loader_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int CNT_W = cnt_width(SIZE)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic incr,
    output logic is_last
);

    logic [CNT_W-1:0] count;

    // Clear wins over increment so a back-to-back accept restarts at zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr) begin
            count <= count + 1'b1;
        end
    end

    assign is_last = (count == CNT_W'(SIZE - 1));

endmodule

// File: rtl/parallel_to_serial_loader.sv
// Loads a parallel word over valid/ready and streams it MSB-first, one bit
// per downstream-consumed cycle.
module parallel_to_serial_loader
    import parallel_to_serial_loader_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    parallel_to_serial_loader_if.slave   bus
);

    state_t          state;
    state_t          state_nxt;
    logic [SIZE-1:0] shreg;
    logic            done_q;
    logic            ready;
    logic            accept;
    logic            consume;
    logic            is_last;

    // The last bit may hand over to a new word in the same edge, so ready
    // opens there only when the bit is actually being consumed.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            IDLE:  ready = 1'b1;
            SHIFT: ready = is_last && bus.shift_ready;
        endcase
        if (!reset) begin
            ready = 1'b0;
        end
        accept  = bus.data_valid && ready;
        consume = (state == SHIFT) && bus.shift_ready;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (consume && is_last && !accept) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            shreg  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= consume && is_last;
            if (accept) begin
                shreg <= bus.data_in;
            end else if (consume) begin
                shreg <= {shreg[SIZE-2:0], 1'b0};
            end
        end
    end

    serializer_bit_counter #(
        .SIZE (SIZE)
    ) u_bit_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept || (consume && is_last)),
        .incr    (consume),
        .is_last (is_last)
    );

    assign bus.data_ready = ready;
    assign bus.out_enable = (state == SHIFT);
    assign bus.busy       = (state == SHIFT);
    assign bus.out        = (state == SHIFT) ? shreg[SIZE-1] : 1'b0;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_parallel_to_serial_loader.sv
// Table-driven bench for the loader, with a model of the downstream shift
// register fed from out/out_enable/shift_ready.
module tb_parallel_to_serial_loader;

    localparam int SIZE = 8;

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [7:0] din;
        logic       sr;
        logic       e_out;
        logic       e_oe;
        logic       e_rdy;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic [SIZE-1:0] ds_reg;
    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    parallel_to_serial_loader_if #(.SIZE(SIZE)) bus ();

    parallel_to_serial_loader #(.SIZE(SIZE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Downstream left-shift register driven the way the real consumer is.
    always @(posedge clk) begin
        if (!reset) begin
            ds_reg <= '0;
        end else if (bus.out_enable && bus.shift_ready) begin
            ds_reg <= {ds_reg[SIZE-2:0], bus.out};
        end
    end

    task automatic check_output(input string name, input logic [7:0] actual,
                                input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic add_vec(input logic rst_n, input logic valid, input logic [7:0] din,
                           input logic sr, input logic e_out, input logic e_oe,
                           input logic e_rdy, input logic e_busy, input logic e_done);
        vec_t v;
        v.rst_n = rst_n; v.valid = valid; v.din = din; v.sr = sr;
        v.e_out = e_out; v.e_oe = e_oe; v.e_rdy = e_rdy;
        v.e_busy = e_busy; v.e_done = e_done;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input vec_t v, input string tag);
        @(negedge clk);
        reset           = v.rst_n;
        bus.data_valid  = v.valid;
        bus.data_in     = v.din;
        bus.shift_ready = v.sr;
        #1;
        check_output({tag, ".out"},        {7'd0, bus.out},        {7'd0, v.e_out});
        check_output({tag, ".out_enable"}, {7'd0, bus.out_enable}, {7'd0, v.e_oe});
        check_output({tag, ".data_ready"}, {7'd0, bus.data_ready}, {7'd0, v.e_rdy});
        check_output({tag, ".busy"},       {7'd0, bus.busy},       {7'd0, v.e_busy});
        check_output({tag, ".done"},       {7'd0, bus.done},       {7'd0, v.e_done});
    endtask

    task automatic run_table(input string tag);
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i], $sformatf("%s[%0d]", tag, i));
        end
        vecs.delete();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] w;
        logic [7:0] w2;

        reset           = 1'b0;
        bus.data_valid  = 1'b0;
        bus.data_in     = '0;
        bus.shift_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Reset held, then idle after release.
        add_vec(0, 1, 8'h3C, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add_vec(1, 0, 8'h00, 0, 0, 0, 1, 0, 0);
        run_table("idle");

        // 8'hA5 with shift_ready always high.
        w = 8'hA5;
        add_vec(1, 1, w, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) add_vec(1, 0, 8'h00, 1, w[7-i], 1, (i == 7), 1, 0);
        add_vec(1, 0, 8'h00, 1, 0, 0, 1, 0, 1);
        add_vec(1, 0, 8'h00, 1, 0, 0, 1, 0, 0);
        run_table("a5");
        check_output("a5.downstream", ds_reg, 8'hA5);

        // 8'hC3 with stalls: odd-numbered bits see two stall cycles first.
        w = 8'hC3;
        apply_stimulus('{1, 1, w, 1, 0, 0, 1, 0, 0}, "c3.accept");
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 1) begin
                for (int s = 0; s < 2; s++)
                    apply_stimulus('{1, 0, 8'h00, 0, w[7-i], 1, 0, 1, 0},
                                   $sformatf("c3.stall%0d_%0d", i, s));
            end
            apply_stimulus('{1, 0, 8'h00, 1, w[7-i], 1, (i == 7), 1, 0},
                           $sformatf("c3.bit%0d", i));
        end
        apply_stimulus('{1, 0, 8'h00, 1, 0, 0, 1, 0, 1}, "c3.done");
        apply_stimulus('{1, 0, 8'h00, 1, 0, 0, 1, 0, 0}, "c3.after");
        check_output("c3.downstream", ds_reg, 8'hC3);

        // Back-to-back 8'hFF then 8'h00 with no bubble.
        add_vec(1, 1, 8'hFF, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) add_vec(1, 1, 8'h00, 1, 1, 1, (i == 7), 1, 0);
        for (int i = 0; i < 8; i++) add_vec(1, (i < 7), 8'h00, 1, 0, 1, (i == 7), 1, (i == 0));
        add_vec(1, 0, 8'h00, 1, 0, 0, 1, 0, 1);
        run_table("b2b");

        // Last bit stalled while a new word waits.
        w  = 8'hAA;
        w2 = 8'h55;
        add_vec(1, 1, w, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) add_vec(1, 0, 8'h00, 1, w[7-i], 1, 0, 1, 0);
        add_vec(1, 1, w2, 0, w[0], 1, 0, 1, 0);
        add_vec(1, 1, w2, 0, w[0], 1, 0, 1, 0);
        add_vec(1, 1, w2, 1, w[0], 1, 1, 1, 0);
        for (int i = 0; i < 8; i++) add_vec(1, 0, 8'h00, 1, w2[7-i], 1, (i == 7), 1, (i == 0));
        add_vec(1, 0, 8'h00, 1, 0, 0, 1, 0, 1);
        run_table("stall_last");

        // Reset during bit 4 of 8'hF0, then a clean 8'h0F.
        add_vec(1, 1, 8'hF0, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) add_vec(1, 0, 8'h00, 1, 1, 1, 0, 1, 0);
        add_vec(0, 0, 8'h00, 1, 1, 1, 0, 1, 0);
        add_vec(0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
        add_vec(1, 0, 8'h00, 1, 0, 0, 1, 0, 0);
        w = 8'h0F;
        add_vec(1, 1, w, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) add_vec(1, 0, 8'h00, 1, w[7-i], 1, (i == 7), 1, 0);
        add_vec(1, 0, 8'h00, 1, 0, 0, 1, 0, 1);
        add_vec(1, 0, 8'h00, 1, 0, 0, 1, 0, 0);
        run_table("rst_mid");
        check_output("rst_mid.downstream", ds_reg, 8'h0F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parallel_to_serial_loader.md
Name: parallel_to_serial_loader

Overview:
- Upstream feeder for the serial left-shift register.
- Accepts a SIZE-bit parallel word through a valid/ready handshake.
- Emits the word MSB-first, one bit per consumed cycle, on `out`, qualified by `out_enable`.
- `out` drives the shift register's `in`; `out_enable` gated with `shift_ready` drives its `enable`. After SIZE consumed bits, the downstream MSB holds the original word's MSB.

Parameters:
- SIZE, 8, word width and number of serial bits per word (≥2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- data_in  input  SIZE  parallel word to serialise.
- data_valid  input  1  data_in valid.
- data_ready  output  1  loader can accept a word this cycle.
- shift_ready  input  1  downstream consumes the current bit this cycle.
- out  output  1  current serial bit.
- out_enable  output  1  `out` holds a valid bit.
- busy  output  1  a word is in flight (SHIFT state).
- done  output  1  one-cycle pulse after the last bit of a word is consumed.

Behaviour:
- Reset: sampled only on the rising clk edge, active when low. While low:
  - state=IDLE, shift reg=0, bit_cnt=0.
  - out=0, out_enable=0, busy=0, done=0.
  - data_ready forced 0.
- Reset asserted mid-word aborts the word: no done pulse, bits lost. First cycle after release is IDLE with data_ready=1.
- States:
  - IDLE: out_enable=0, out=0, busy=0, data_ready=1.
  - SHIFT: out_enable=1, busy=1, out=shreg[SIZE-1].
- Accept occurs when data_valid && data_ready at the clock edge. The word is latched into shreg, bit_cnt=0, state→SHIFT.
- Latency: the first bit (data_in[SIZE-1]) appears on `out` with out_enable=1 in the cycle after accept.
- Consume occurs when in SHIFT && shift_ready at the edge:
  - shreg shifts left by 1, zero fill.
  - bit_cnt increments.
- Stall: when in SHIFT && !shift_ready, out, out_enable, shreg and bit_cnt all hold.
- Last bit (bit_cnt==SIZE-1):
  - data_ready=1 combinationally iff shift_ready=1; otherwise 0.
  - On consume with no accept: state→IDLE, done=1 next cycle.
  - On consume with simultaneous accept: state stays SHIFT, new word loaded, done=1 next cycle. Back-to-back words have zero bubble.
- data_ready is 0 in SHIFT except in the last-bit case above. data_in is ignored when not accepted.
- bit_cnt width is CNT_W=$clog2(SIZE). It never wraps past SIZE-1; reaching the last bit ends the word.
- done is a registered pulse, exactly 1 cycle per completed word.

Decomposition:
- Shared package holds:
  - state encoding localparams ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - CNT_W function/constant derived from SIZE.
- One natural sub-module: serializer_bit_counter. It is a CNT_W-bit counter with synchronous active-low reset, clear (on accept), increment (on consume) and is_last flag.
- Shift register and FSM stay inline.

Test Plan:
- Reset release, data_valid=0 → data_ready=1, out_enable=0, out=0, busy=0, done=0 indefinitely.
- SIZE=8, accept 8'hA5, shift_ready=1 constant:
  - out = 1,0,1,0,0,1,0,1 on cycles 1..8 after accept, out_enable=1 throughout.
  - done=1 on cycle 9.
  - With the shift register enabled on out_enable&&shift_ready, its parallel state = 8'hA5 after bit 8.
- Accept 8'hC3, toggle shift_ready (1,0,0,1,...) → each bit holds through stall cycles; sequence still 1,1,0,0,0,0,1,1; done only after the 8th consume.
- Back-to-back: 8'hFF then 8'h00 with data_valid held → 16 consecutive out_enable=1 cycles (8 ones, 8 zeros), data_ready=1 only on cycles 8 and 16, two done pulses.
- Last bit with shift_ready=0 and data_valid=1 → data_ready=0, no accept until shift_ready=1.
- Reset low at bit 4 of 8'hF0 → next cycle out_enable=0, no done. After release, accept 8'h0F → clean sequence 0,0,0,0,1,1,1,1.
